// File: rtl/pmem_responder.sv
// Single-port line memory that answers pmem read/write requests after a fixed latency.
// Out-of-range addresses and simultaneous read+write complete with an error and leave storage untouched.
module pmem_responder #(
  parameter int          LATENCY   = 4,
  parameter int          DEPTH     = 16,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         pmem_read,
  input  logic         pmem_write,
  input  logic [31:0]  pmem_address,
  input  logic [255:0] pmem_wdata,
  output logic         pmem_resp,
  output logic         pmem_error,
  output logic [255:0] pmem_rdata,
  output logic         busy
);

  localparam int          IDX_W      = $clog2(DEPTH);
  localparam logic [32:0] LIMIT      = {1'b0, BASE_ADDR} + 33'(DEPTH) * 33'd32;
  localparam logic [7:0]  COUNT_INIT = 8'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t         state_reg;
  logic [7:0]     count_reg;
  logic           rd_reg;
  logic           wr_reg;
  logic [31:0]    addr_reg;
  logic [255:0]   wdata_reg;
  logic           resp_reg;
  logic           error_reg;
  logic [255:0]   rdata_reg;
  logic [255:0]   mem_reg [DEPTH];

  logic             sel_rd;
  logic             sel_wr;
  logic [31:0]      sel_addr;
  logic [31:0]      offset;
  logic             in_range;
  logic [IDX_W-1:0] idx;
  logic             resp_err;
  logic [255:0]     resp_data;
  logic             commit_we;
  logic [DEPTH-1:0] line_we;
  logic             unused_offset_bits;

  // With LATENCY=1 the response is formed in the acceptance cycle, so the
  // live inputs stand in for the not-yet-latched request while in IDLE.
  always_comb begin
    sel_rd    = (state_reg == IDLE) ? pmem_read    : rd_reg;
    sel_wr    = (state_reg == IDLE) ? pmem_write   : wr_reg;
    sel_addr  = (state_reg == IDLE) ? pmem_address : addr_reg;
    offset    = sel_addr - BASE_ADDR;
    in_range  = ({1'b0, sel_addr} >= {1'b0, BASE_ADDR}) && ({1'b0, sel_addr} < LIMIT);
    idx       = offset[5 +: IDX_W];
    resp_err  = (sel_rd && sel_wr) || !in_range;
    resp_data = '0;
    if (sel_rd && !resp_err) begin
      resp_data = mem_reg[idx];
    end
    commit_we = (state_reg == RESP) && wr_reg && !rd_reg && in_range;
  end

  assign unused_offset_bits = ^{offset[31:5+IDX_W], offset[4:0]};

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_line_we
      assign line_we[gi] = commit_we && (idx == IDX_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      count_reg <= '0;
      rd_reg    <= 1'b0;
      wr_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      resp_reg  <= 1'b0;
      error_reg <= 1'b0;
      rdata_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (pmem_read || pmem_write) begin
            rd_reg    <= pmem_read;
            wr_reg    <= pmem_write;
            addr_reg  <= pmem_address;
            wdata_reg <= pmem_wdata;
            count_reg <= COUNT_INIT;
            if (LATENCY == 1) begin
              state_reg <= RESP;
              resp_reg  <= 1'b1;
              error_reg <= resp_err;
              rdata_reg <= resp_data;
            end else begin
              state_reg <= BUSY;
            end
          end
        end
        BUSY: begin
          count_reg <= count_reg - 8'd1;
          if (count_reg == 8'd1) begin
            state_reg <= RESP;
            resp_reg  <= 1'b1;
            error_reg <= resp_err;
            rdata_reg <= resp_data;
          end
        end
        RESP: begin
          resp_reg  <= 1'b0;
          error_reg <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Write data lands on the edge that closes the RESP cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (line_we[i]) begin
          mem_reg[i] <= wdata_reg;
        end
      end
    end
  end

  assign pmem_resp  = resp_reg;
  assign pmem_error = error_reg;
  assign pmem_rdata = rdata_reg;
  assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_pmem_responder.sv
// Scoreboard bench for pmem_responder: instance A uses LATENCY=4, instance B uses LATENCY=1.
// Expected responses come from a per-instance line model and are queued before each request is driven.
module tb_pmem_responder;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         rd_a = 1'b0, wr_a = 1'b0, rd_b = 1'b0, wr_b = 1'b0;
  logic [31:0]  addr_a = '0, addr_b = '0;
  logic [255:0] wdata_a = '0, wdata_b = '0;
  logic         resp_a, err_a, busy_a, resp_b, err_b, busy_b;
  logic [255:0] rdata_a, rdata_b;

  typedef struct {
    string        name;
    logic         err;
    logic         chk_data;
    logic [255:0] data;
    int           lat;
    int           idle;
  } exp_t;

  exp_t         exp_q[$];
  logic [255:0] model_a [16];
  logic [255:0] model_b [16];
  int           n_tests = 0;
  int           n_fail  = 0;

  always #5 clk = ~clk;

  pmem_responder #(.LATENCY(4), .DEPTH(16), .BASE_ADDR(32'h0)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .pmem_read(rd_a), .pmem_write(wr_a),
    .pmem_address(addr_a), .pmem_wdata(wdata_a), .pmem_resp(resp_a),
    .pmem_error(err_a), .pmem_rdata(rdata_a), .busy(busy_a));

  pmem_responder #(.LATENCY(1), .DEPTH(16), .BASE_ADDR(32'h0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .pmem_read(rd_b), .pmem_write(wr_b),
    .pmem_address(addr_b), .pmem_wdata(wdata_b), .pmem_resp(resp_b),
    .pmem_error(err_b), .pmem_rdata(rdata_b), .busy(busy_b));

  task automatic drive(input bit sel, input logic rd, input logic wr,
                       input logic [31:0] addr, input logic [255:0] wd);
    if (sel) begin
      rd_b = rd; wr_b = wr; addr_b = addr; wdata_b = wd;
    end else begin
      rd_a = rd; wr_a = wr; addr_a = addr; wdata_a = wd;
    end
  endtask

  task automatic clear_models();
    for (int i = 0; i < 16; i++) begin
      model_a[i] = '0;
      model_b[i] = '0;
    end
  endtask

  // Predicts the response from the model and applies a successful write to it.
  task automatic push_exp(input bit sel, input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [255:0] wd, input string name, input int lat, input int idle);
    exp_t       e;
    logic       in_r;
    logic [3:0] li;
    in_r       = (addr < 32'd512);
    li         = addr[8:5];
    e.name     = name;
    e.lat      = lat;
    e.idle     = idle;
    e.err      = (rd && wr) || !in_r;
    e.chk_data = rd || e.err;
    e.data     = '0;
    if (rd && !e.err) e.data = sel ? model_b[li] : model_a[li];
    if (wr && !rd && in_r) begin
      if (sel) model_b[li] = wd;
      else     model_a[li] = wd;
    end
    exp_q.push_back(e);
  endtask

  // Drives one request and waits (bounded) for its response; requests drop once pmem_resp is seen.
  task automatic run(input bit sel, input logic rd, input logic wr, input logic [31:0] addr,
                     input logic [255:0] wd, input bit mid_chg, input logic [31:0] mid_addr,
                     output bit got, output int lat, output int idle, output int busy_hi,
                     output logic err, output logic [255:0] data, output bit leak);
    int           first_busy;
    logic         r_s, e_s, b_s;
    logic [255:0] d_s;
    first_busy = -1; got = 0; lat = 0; idle = 0; busy_hi = 0; err = 1'b0; data = '0; leak = 0;
    drive(sel, rd, wr, addr, wd);
    for (int c = 1; c <= 300; c++) begin
      @(posedge clk); #1;
      r_s = sel ? resp_b  : resp_a;
      e_s = sel ? err_b   : err_a;
      b_s = sel ? busy_b  : busy_a;
      d_s = sel ? rdata_b : rdata_a;
      if (b_s) begin
        busy_hi++;
        if (first_busy < 0) begin
          first_busy = c;
          if (mid_chg) begin
            if (sel) addr_b = mid_addr;
            else     addr_a = mid_addr;
          end
        end
      end
      if (e_s && !r_s) leak = 1;
      if (r_s) begin
        got = 1; lat = c - first_busy + 1; idle = first_busy - 1; err = e_s; data = d_s;
        break;
      end
    end
    drive(sel, 1'b0, 1'b0, addr, '0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({resp_a, err_a, busy_a, rdata_a} !== {3'b000, 256'h0}) begin
      n_fail++;
      $display("FAIL reset_a: resp=%0b err=%0b busy=%0b rdata=%h, expected all zero", resp_a, err_a, busy_a, rdata_a);
    end
    n_tests++;
    if ({resp_b, err_b, busy_b, rdata_b} !== {3'b000, 256'h0}) begin
      n_fail++;
      $display("FAIL reset_b: resp=%0b err=%0b busy=%0b rdata=%h, expected all zero", resp_b, err_b, busy_b, rdata_b);
    end
    clear_models();
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Generic scenario body: a table of transactions issued back to back on one instance.
  task automatic test_table(input string tname, input bit sel, input int n,
                            input logic [31:0] addrs [20], input logic [1:0] ops [20],
                            input logic [255:0] wds [20], input int idle0, input int exp_busy);
    bit got, leak; int lat, idle, bh; logic err; logic [255:0] data; exp_t e;
    for (int i = 0; i < n; i++) begin
      push_exp(sel, ops[i][0], ops[i][1], addrs[i], wds[i], $sformatf("%s[%0d]", tname, i),
               sel ? 1 : 4, (i == 0) ? idle0 : 1);
      run(sel, ops[i][0], ops[i][1], addrs[i], wds[i], 1'b0, '0, got, lat, idle, bh, err, data, leak);
      e = exp_q.pop_front();
      n_tests++;
      if (!got || lat != e.lat || (e.idle >= 0 && idle != e.idle) || (exp_busy > 0 && bh != exp_busy)) begin
        n_fail++;
        $display("FAIL %s timing: resp=%0b lat=%0d idle=%0d busy_cycles=%0d, expected lat=%0d idle=%0d busy_cycles=%0d",
                 e.name, got, lat, idle, bh, e.lat, e.idle, exp_busy);
      end
      n_tests++;
      if (err !== e.err || (e.chk_data && data !== e.data) || leak) begin
        n_fail++;
        $display("FAIL %s response: err=%0b rdata=%h stray_err=%0b, expected err=%0b rdata=%h",
                 e.name, err, data, leak, e.err, e.data);
      end
      $display("[TB] %s op=%0d addr=%h lat=%0d err=%0b", e.name, ops[i], addrs[i], lat, err);
    end
  endtask

  task automatic test_write_read();
    logic [31:0] a [20]; logic [1:0] o [20]; logic [255:0] w [20];
    a[0] = 32'h40; o[0] = 2'b10; w[0] = {8{32'hDEADBEEF}};
    a[1] = 32'h5F; o[1] = 2'b01; w[1] = '0;
    test_table("write_read", 1'b0, 2, a, o, w, 0, 4);
    @(posedge clk); #1;
    n_tests++;
    if ({resp_a, err_a, rdata_a} !== {2'b00, {8{32'hDEADBEEF}}}) begin
      n_fail++;
      $display("FAIL rdata_hold: resp=%0b err=%0b rdata=%h, expected resp=0 err=0 rdata=%h",
               resp_a, err_a, rdata_a, {8{32'hDEADBEEF}});
    end
  endtask

  task automatic test_latency1_back_to_back();
    logic [31:0] a [20]; logic [1:0] o [20]; logic [255:0] w [20];
    a[0] = 32'h00; o[0] = 2'b01; w[0] = '0;
    a[1] = 32'h20; o[1] = 2'b01; w[1] = '0;
    test_table("lat1_b2b", 1'b1, 2, a, o, w, 0, 1);
    @(posedge clk); #1;
    n_tests++;
    if (busy_b !== 1'b0) begin
      n_fail++;
      $display("FAIL lat1_busy_drop: busy=%0b, expected 0", busy_b);
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] a [20]; logic [1:0] o [20]; logic [255:0] w [20];
    a[0] = 32'h200; o[0] = 2'b01; w[0] = '0;
    a[1] = 32'h200; o[1] = 2'b10; w[1] = {8{32'h0BAD_0BAD}};
    for (int i = 0; i < 16; i++) begin
      a[i+2] = 32'(i * 32); o[i+2] = 2'b01; w[i+2] = '0;
    end
    test_table("out_of_range", 1'b0, 18, a, o, w, -1, 4);
  endtask

  task automatic test_both_high();
    logic [31:0] a [20]; logic [1:0] o [20]; logic [255:0] w [20];
    a[0] = 32'h20; o[0] = 2'b10; w[0] = {4{64'h0123_4567_89AB_CDEF}};
    a[1] = 32'h20; o[1] = 2'b11; w[1] = {8{32'h5555_AAAA}};
    a[2] = 32'h20; o[2] = 2'b01; w[2] = '0;
    test_table("both_high", 1'b0, 3, a, o, w, -1, 4);
  endtask

  task automatic test_reset_abort();
    logic [31:0] a [20]; logic [1:0] o [20]; logic [255:0] w [20];
    bit saw_resp;
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 32'h60, {8{32'hCAFE_F00D}});
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({busy_a, resp_a, err_a} !== 3'b000) begin
      n_fail++;
      $display("FAIL abort_reset_now: busy=%0b resp=%0b err=%0b, expected 0 0 0", busy_a, resp_a, err_a);
    end
    drive(1'b0, 1'b0, 1'b0, 32'h60, '0);
    clear_models();
    #2 rst_n = 1'b1;
    saw_resp = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (resp_a || busy_a) saw_resp = 1;
    end
    n_tests++;
    if (saw_resp) begin
      n_fail++;
      $display("FAIL abort_no_resp: resp or busy seen after aborted write, expected none");
    end
    a[0] = 32'h60; o[0] = 2'b01; w[0] = '0;
    a[1] = 32'h40; o[1] = 2'b01; w[1] = '0;
    test_table("reset_abort", 1'b0, 2, a, o, w, 0, 4);
  endtask

  task automatic test_addr_change();
    bit got, leak; int lat, idle, bh; logic err; logic [255:0] data; exp_t e;
    logic [31:0] a [20]; logic [1:0] o [20]; logic [255:0] w [20];
    a[0] = 32'h40; o[0] = 2'b10; w[0] = {8{32'hDEADBEEF}};
    test_table("addr_change_setup", 1'b0, 1, a, o, w, -1, 4);
    push_exp(1'b0, 1'b1, 1'b0, 32'h40, '0, "addr_change", 4, 1);
    run(1'b0, 1'b1, 1'b0, 32'h40, '0, 1'b1, 32'h80, got, lat, idle, bh, err, data, leak);
    e = exp_q.pop_front();
    n_tests++;
    if (!got || lat != e.lat || err !== e.err || data !== e.data) begin
      n_fail++;
      $display("FAIL %s: resp=%0b lat=%0d err=%0b rdata=%h, expected lat=%0d err=%0b rdata=%h",
               e.name, got, lat, err, data, e.lat, e.err, e.data);
    end
    $display("[TB] %s addr=00000040->00000080 lat=%0d err=%0b", e.name, lat, err);
  endtask

  task automatic test_random();
    logic [31:0] a [20]; logic [1:0] o [20]; logic [255:0] w [20];
    for (int i = 0; i < 20; i++) begin
      a[i] = 32'($urandom_range(0, 19) * 32 + $urandom_range(0, 31));
      o[i] = 2'($urandom_range(1, 3));
      for (int k = 0; k < 8; k++) w[i][k*32 +: 32] = $urandom;
    end
    test_table("random_a", 1'b0, 20, a, o, w, -1, 4);
    test_table("random_b", 1'b1, 20, a, o, w, -1, 1);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_latency1_back_to_back();
    test_out_of_range();
    test_both_high();
    test_reset_abort();
    test_addr_change();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached before the bench finished");
    $fatal(1, "watchdog");
  end

endmodule
